dac_i2s_serializer: RTL and testbench

//   Downstream stage of the IIR filter. Recovers LRCLK/BCLK edges from the codec clock pins and

---
 rtl/dac_i2s_serializer.sv | 156 +++++++++++++++
 tb/tb_dac_i2s_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_i2s_serializer.sv
// I2S serializer for the IIR filter output: synchronizes the codec BCLK/LRCLK pins,
// saturates the signed sample to OUT_W bits and shifts it MSB-first on DACDAT in both slots.
module dac_i2s_serializer #(
    parameter int IN_W   = 21,
    parameter int OUT_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_bclk,
    input  logic            i_lrclk,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_audio,
    input  logic            i_sat_clr,
    output logic            o_lrclk_posedge,
    output logic            o_lrclk_negedge,
    output logic            o_dacdat,
    output logic            o_busy,
    output logic            o_frame_err,
    output logic [15:0]     o_sat_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(OUT_W);
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [SYNC_N-1:0] bclk_sync;
    logic [SYNC_N-1:0] lrclk_sync;
    logic              bclk_prev;
    logic              lrclk_prev;
    logic              bclk_fall;
    logic              lr_pulse;

    state_t            state;
    state_t            state_n;
    logic [OUT_W-1:0]  shreg;
    logic [OUT_W-1:0]  shreg_n;
    logic [CNT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  bitcnt_n;
    logic              dacdat_n;
    logic              frame_err_n;

    logic signed [IN_W-1:0] audio_s;
    logic                   clip_hi;
    logic                   clip_lo;
    logic [OUT_W-1:0]       sat_val;

    // Edge pulses are registered, so they land SYNC_N+1 clk cycles after the pin toggles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync       <= '0;
            lrclk_sync      <= '0;
            bclk_prev       <= 1'b0;
            lrclk_prev      <= 1'b0;
            bclk_fall       <= 1'b0;
            o_lrclk_posedge <= 1'b0;
            o_lrclk_negedge <= 1'b0;
        end else begin
            bclk_sync       <= {bclk_sync[SYNC_N-2:0], i_bclk};
            lrclk_sync      <= {lrclk_sync[SYNC_N-2:0], i_lrclk};
            bclk_prev       <= bclk_sync[SYNC_N-1];
            lrclk_prev      <= lrclk_sync[SYNC_N-1];
            bclk_fall       <= ~bclk_sync[SYNC_N-1] & bclk_prev;
            o_lrclk_posedge <= lrclk_sync[SYNC_N-1] & ~lrclk_prev;
            o_lrclk_negedge <= ~lrclk_sync[SYNC_N-1] & lrclk_prev;
        end
    end

    assign lr_pulse = o_lrclk_posedge | o_lrclk_negedge;

    assign audio_s = $signed(i_audio);
    assign clip_hi = (audio_s > SAT_MAX);
    assign clip_lo = (audio_s < SAT_MIN);

    always_comb begin
        sat_val = i_audio[OUT_W-1:0];
        if (clip_hi) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (clip_lo) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sat_count <= '0;
        end else if (i_sat_clr) begin
            o_sat_count <= '0;
        end else if (lr_pulse && i_valid && (clip_hi || clip_lo) && (o_sat_count != 16'hFFFF)) begin
            o_sat_count <= o_sat_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            o_dacdat    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bitcnt      <= bitcnt_n;
            o_dacdat    <= dacdat_n;
            o_frame_err <= frame_err_n;
        end
    end

    // An lrclk pulse outranks a same-cycle bclk fall: that fall is swallowed and the word restarts.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bitcnt_n    = bitcnt;
        dacdat_n    = o_dacdat;
        frame_err_n = 1'b0;
        if (lr_pulse) begin
            frame_err_n = (state != IDLE);
            shreg_n     = i_valid ? sat_val : '0;
            bitcnt_n    = '0;
            dacdat_n    = 1'b0;
            state_n     = ARM;
        end else if (bclk_fall) begin
            case (state)
                ARM: begin
                    dacdat_n = shreg[OUT_W-1];
                    shreg_n  = {shreg[OUT_W-2:0], 1'b0};
                    bitcnt_n = CNT_W'(OUT_W-1);
                    state_n  = SHIFT;
                end
                SHIFT: begin
                    if (bitcnt != '0) begin
                        dacdat_n = shreg[OUT_W-1];
                        shreg_n  = {shreg[OUT_W-2:0], 1'b0};
                        bitcnt_n = bitcnt - CNT_W'(1);
                    end else begin
                        dacdat_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_dac_i2s_serializer.sv
// Directed bench for dac_i2s_serializer: reset, edge-pulse latency, word shifting,
// saturation and its counter, invalid input, short frames and reset mid-word.
module tb_dac_i2s_serializer;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_bclk;
    logic        i_lrclk;
    logic        i_valid;
    logic [20:0] i_audio;
    logic        i_sat_clr;
    logic        o_lrclk_posedge;
    logic        o_lrclk_negedge;
    logic        o_dacdat;
    logic        o_busy;
    logic        o_frame_err;
    logic [15:0] o_sat_count;

    int total = 0;
    int bad   = 0;
    int pos_cnt = 0, neg_cnt = 0, fe_cnt = 0, wide = 0;
    int exp_pos = 0, exp_neg = 0;
    logic pos_q = 1'b0, neg_q = 1'b0, fe_q = 1'b0;

    dac_i2s_serializer dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_bclk          (i_bclk),
        .i_lrclk         (i_lrclk),
        .i_valid         (i_valid),
        .i_audio         (i_audio),
        .i_sat_clr       (i_sat_clr),
        .o_lrclk_posedge (o_lrclk_posedge),
        .o_lrclk_negedge (o_lrclk_negedge),
        .o_dacdat        (o_dacdat),
        .o_busy          (o_busy),
        .o_frame_err     (o_frame_err),
        .o_sat_count     (o_sat_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // pulse monitor: counts pulses and flags any pulse wider than one cycle
    always @(negedge clk) begin
        if (o_lrclk_posedge) pos_cnt++;
        if (o_lrclk_negedge) neg_cnt++;
        if (o_frame_err) fe_cnt++;
        if ((o_lrclk_posedge && pos_q) || (o_lrclk_negedge && neg_q) || (o_frame_err && fe_q)) wide++;
        pos_q = o_lrclk_posedge;
        neg_q = o_lrclk_negedge;
        fe_q  = o_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n full bclk periods; act reports any dacdat/busy activity seen
    task automatic idle_run(input int n, output logic act);
        act = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_bclk = 1'b1;
            repeat (HALF) begin @(negedge clk); act |= o_dacdat | o_busy; end
            i_bclk = 1'b0;
            repeat (HALF) begin @(negedge clk); act |= o_dacdat | o_busy; end
        end
    endtask

    // lrclk toggles together with a bclk fall, then nbits bits are checked after later falls
    task automatic run_word(input string tag, input logic [15:0] exp, input int nbits, input logic clr_at_cap);
        i_bclk = 1'b1;
        repeat (HALF) @(negedge clk);
        i_bclk  = 1'b0;
        i_lrclk = ~i_lrclk;
        if (i_lrclk) exp_pos++; else exp_neg++;
        if (clr_at_cap) begin
            repeat (3) @(negedge clk);
            i_sat_clr = 1'b1;
            @(negedge clk);
            i_sat_clr = 1'b0;
            repeat (HALF-4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        check($sformatf("%s_arm_dat", tag), o_dacdat, 0);
        check($sformatf("%s_arm_busy", tag), o_busy, 1);
        for (int i = 0; i < nbits; i++) begin
            i_bclk = 1'b1;
            repeat (HALF) @(negedge clk);
            i_bclk = 1'b0;
            repeat (HALF) @(negedge clk);
            check($sformatf("%s_b%0d", tag, i), o_dacdat, exp[15-i]);
        end
        if (nbits == 16) begin
            i_bclk = 1'b1;
            repeat (HALF) @(negedge clk);
            i_bclk = 1'b0;
            repeat (HALF) @(negedge clk);
            check($sformatf("%s_end_busy", tag), o_busy, 0);
            check($sformatf("%s_end_dat", tag), o_dacdat, 0);
        end
    endtask

    task automatic edge_latency(input string tag, input logic rise);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        i_lrclk = rise;
        if (rise) exp_pos++; else exp_neg++;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (rise ? o_lrclk_posedge : o_lrclk_negedge) seen = 1'b1;
        end
        check(tag, seen ? n : 0, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic act;
        logic [20:0] outs;
        i_rst_n = 1'b0; i_bclk = 1'b0; i_lrclk = 1'b0;
        i_valid = 1'b1; i_audio = '0; i_sat_clr = 1'b0;

        // reset held while pins toggle
        act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_bclk = ~i_bclk;
            if (i % 3 == 0) i_lrclk = ~i_lrclk;
            repeat (3) begin
                @(negedge clk);
                act |= o_lrclk_posedge | o_lrclk_negedge | o_dacdat | o_busy | o_frame_err | (o_sat_count != 0);
            end
        end
        check("reset_activity", act, 0);
        outs = {o_lrclk_posedge, o_lrclk_negedge, o_dacdat, o_busy, o_frame_err, o_sat_count};
        check("reset_outs", outs, 0);
        i_lrclk = 1'b0;
        i_bclk  = 1'b1;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        idle_run(20, act);
        check("post_reset_idle", act, 0);
        check("post_reset_pulses", pos_cnt + neg_cnt, 0);

        // edge-pulse latency: one lrclk period, bclk held high
        i_bclk = 1'b1;
        repeat (HALF) @(negedge clk);
        edge_latency("pos_latency", 1'b1);
        repeat (HALF) @(negedge clk);
        edge_latency("neg_latency", 1'b0);
        repeat (HALF) @(negedge clk);
        check("one_pos_pulse", pos_cnt, 1);
        check("one_neg_pulse", neg_cnt, 1);
        check("abort_in_arm", fe_cnt, 1);
        idle_run(17, act);
        check("flush_idle", o_busy, 0);

        // normal word
        i_audio = 21'h00ABC;
        run_word("abc", 16'h0ABC, 16, 1'b0);
        check("abc_cnt", o_sat_count, 0);

        // saturation and the clip counter
        i_audio = 21'(40000);
        run_word("p40k", 16'h7FFF, 16, 1'b0);
        check("p40k_cnt", o_sat_count, 1);
        i_audio = 21'(-40000);
        run_word("n40k", 16'h8000, 16, 1'b0);
        check("n40k_cnt", o_sat_count, 2);
        i_audio = 21'(32767);
        run_word("pmax", 16'h7FFF, 16, 1'b0);
        check("pmax_cnt", o_sat_count, 2);
        i_audio = 21'(-32768);
        run_word("nmin", 16'h8000, 16, 1'b0);
        check("nmin_cnt", o_sat_count, 2);

        // invalid input loads zeros and never counts
        i_valid = 1'b0;
        i_audio = 21'h1FFFF;
        run_word("inval", 16'h0000, 16, 1'b0);
        check("inval_cnt", o_sat_count, 2);
        i_valid = 1'b1;

        // clear in the capture cycle beats the increment
        i_audio = 21'(40000);
        run_word("clrcap", 16'h7FFF, 16, 1'b1);
        check("clrcap_cnt", o_sat_count, 0);
        run_word("p40k2", 16'h7FFF, 16, 1'b0);
        check("p40k2_cnt", o_sat_count, 1);
        i_sat_clr = 1'b1;
        @(negedge clk);
        i_sat_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt", o_sat_count, 0);

        // short frame: abort after 8 bits, fresh word follows
        i_audio = 21'h00ABC;
        run_word("short", 16'h0ABC, 8, 1'b0);
        i_audio = 21'h01234;
        run_word("fresh", 16'h1234, 16, 1'b0);
        check("short_frame_err", fe_cnt, 2);

        // reset mid-word drops the word
        i_audio = 21'h07FFF;
        run_word("drop", 16'h7FFF, 4, 1'b0);
        i_bclk  = 1'b1;
        i_rst_n = 1'b0;
        i_lrclk = 1'b0;
        repeat (3) @(negedge clk);
        outs = {o_lrclk_posedge, o_lrclk_negedge, o_dacdat, o_busy, o_frame_err, o_sat_count};
        check("midword_reset_outs", outs, 0);
        i_bclk = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        idle_run(20, act);
        check("midword_no_resume", act, 0);

        check("pos_total", pos_cnt, exp_pos);
        check("neg_total", neg_cnt, exp_neg);
        check("pulse_width", wide, 0);
        check("frame_err_total", fe_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
